cordic_fixed_to_float: RTL and testbench
========================================

# cordic_fixed_to_float

Pipelined converter from the CORDIC core's signed fixed-point cosine result to an IEEE-754 single-precision word. It sits directly downstream of the unrolled CORDIC datapath and drives the custom-instruction `result` port. It replaces the current pass-through of the fixed-point word. Three stages: leading-one detect, normalise, then round and pack. Stalls with `clk_en` like the rest of the accelerator.

## Interface

Parameters:
- `FRAC_BITS`, default 31: number of fractional bits in the input. Input value = `fixed_in` / 2^FRAC_BITS. Legal range 0..31.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `clk_en`  in  1: pipeline advance enable. Low holds every register.
- `in_valid`  in  1: `fixed_in` is valid this cycle. Sampled only when `clk_en`=1.
- `fixed_in`  in  32: two's-complement fixed-point value.
- `out_valid`  out  1: `float_out` is valid.
- `float_out`  out  32: IEEE-754 single {sign, exp[7:0], mant[22:0]}.

## Operation

- **Stage 1 (capture/encode)**
  - sign = `fixed_in[31]`.
  - mag = |`fixed_in`| as 32-bit unsigned. 0x80000000 gives mag 0x80000000.
  - p = index of the leading one of mag, via `priority_encoder32`.
  - zero flag = (mag == 0).
- **Stage 2 (normalise)**
  - norm = mag << (31 − p), so norm[31] = 1.
  - exp = 127 + p − FRAC_BITS, 9-bit unsigned. It stays within 96..158 for legal FRAC_BITS.
- **Stage 3 (round/pack)**
  - mant = norm[30:8], G = norm[7], S = |norm[6:0], L = norm[8].
  - Round to nearest even: round_up = G & (S | L).
  - If mant = 0x7FFFFF and round_up: mant becomes 0 and exp becomes exp + 1.
  - `float_out` = {sign, exp[7:0], mant}.
- Zero input gives +0.0 (0x00000000), never −0.0.
- No subnormals, infinities or NaNs can arise; none are generated.
- No exceptions or flags.
- `in_valid`=0 bubbles propagate as `out_valid`=0. Data registers may hold stale values in that case.

## Timing

- Latency: exactly 3 enabled cycles (`clk_en`=1 edges) from sampling `in_valid`/`fixed_in` to `out_valid`/`float_out`.
- Throughput: one conversion per enabled cycle, fully pipelined.
- `clk_en`=0: all stage registers, including the valid bits, hold. Outputs stay stable for the whole stall.
- Reset, on a rising edge with `reset_n`=0:
  - All valid bits clear.
  - `float_out` = 0x00000000, `out_valid` = 0.
  - Reset takes priority over `clk_en`. It clears the pipeline even while stalled.
- Reset mid-operation: every in-flight conversion is discarded. No stale `out_valid` appears after `reset_n` rises.
- First accepted input after reset: `out_valid` is high on the 3rd enabled edge after sampling.
- The combined pipeline and CORDIC accelerator `n` parameter for the custom instruction grows by 3.

## Structure

- Shared package `cordic_pkg`:
  - `FLOAT_BIAS` = 127, `FLOAT_EXP_W` = 8, `FLOAT_MANT_W` = 23, `FIXED_W` = 32.
  - A packed struct type for the IEEE-754 single fields, also used by the upstream float-to-fixed stage.
- Sub-module: the existing `priority_encoder32`, instantiated once in stage 1. Its `valid` output drives the zero flag.
- The barrel shift and the rounding stay inline. No further sub-modules.

## Test plan

- **Cosine result (`FRAC_BITS`=31):** `fixed_in`=0x6EC1BCCD → `float_out`=0x3F5D837A (≈0.865287), `out_valid` on the 3rd enabled edge.
- **Exact values:** 0x40000000 → 0x3F000000 (0.5); 0x80000000 → 0xBF800000 (−1.0); 0x00000000 → 0x00000000.
- **Rounding:**
  - 0x7FFFFFFF → 0x3F800000 (mantissa overflow bumps the exponent).
  - 0x01000001 → 0x3C000000 (tie, even LSB, no round-up).
  - 0x01000003 → 0x3C000002 (tie, odd LSB, round-up).
- **Back-to-back stream with bubbles:** random `in_valid` pattern. Output order, valid pattern and 3-cycle latency must match a reference model that uses the real-to-float conversion.
- **Stall:** hold `clk_en`=0 for 5 cycles mid-stream → outputs frozen. On resume the sequence continues with no drop or duplicate.
- **Reset with 3 valid conversions in flight:** assert `reset_n`=0 for one edge with `clk_en`=0 → `out_valid`=0 and `float_out`=0 next cycle. No stale outputs afterwards.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants and the IEEE-754 single-precision field layout used by the
// CORDIC accelerator's fixed<->float conversion stages.
package cordic_pkg;

   localparam int FLOAT_BIAS   = 127;
   localparam int FLOAT_EXP_W  = 8;
   localparam int FLOAT_MANT_W = 23;
   localparam int FIXED_W      = 32;
   localparam int FIXED_POS_W  = $clog2(FIXED_W);

   typedef struct packed {
      logic                    sign;
      logic [FLOAT_EXP_W-1:0]  exp;
      logic [FLOAT_MANT_W-1:0] mant;
   } float32_t;

endpackage

// File: rtl/priority_encoder32.sv
// Leading-one detector: idx is the position of the most significant set bit
// of req; valid is low when req is all zeros (idx is then 0).
module priority_encoder32
   import cordic_pkg::*;
(
   input  logic [FIXED_W-1:0]     req,
   output logic [FIXED_POS_W-1:0] idx,
   output logic                   valid
);

   always_comb begin
      // NOTE: default assignment before the loop keeps this purely combinational (no latch).
      idx = '0;
      for (int i = 0; i < FIXED_W; i++) begin
         if (req[i]) idx = FIXED_POS_W'(i);
      end
   end

   assign valid = |req;

endmodule

// File: rtl/cordic_fixed_to_float.sv
// Three-stage pipelined converter from signed fixed-point (FRAC_BITS fraction
// bits) to IEEE-754 single: leading-one detect, normalise, round-to-nearest-even and pack.
module cordic_fixed_to_float
   import cordic_pkg::*;
#(
   parameter int FRAC_BITS = 31
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               clk_en,
   input  logic               in_valid,
   input  logic [FIXED_W-1:0] fixed_in,
   output logic               out_valid,
   output logic [31:0]        float_out
);

   // Stage 1: sign, magnitude, leading-one position
   logic [FIXED_W-1:0]     mag;
   logic [FIXED_POS_W-1:0] lead_pos;
   logic                   lead_found;

   logic                   s1_valid;
   logic                   s1_sign;
   logic                   s1_zero;
   logic [FIXED_W-1:0]     s1_mag;
   logic [FIXED_POS_W-1:0] s1_pos;

   // Stage 2: normalised magnitude with the hidden one dropped, biased exponent
   logic                   s2_valid;
   logic                   s2_sign;
   logic                   s2_zero;
   logic [FIXED_W-2:0]     s2_norm;
   logic [8:0]             s2_exp;

   // Stage 3 combinational rounding
   logic                   guard_bit;
   logic                   sticky_bit;
   logic                   lsb_bit;
   logic                   round_up;
   logic [FLOAT_MANT_W:0]  mant_rnd;
   logic [8:0]             exp_rnd;
   float32_t               packed_word;

   assign mag = fixed_in[FIXED_W-1] ? -fixed_in : fixed_in;

   priority_encoder32 u_lead_one (
      .req   (mag),
      .idx   (lead_pos),
      .valid (lead_found)
   );

   // NOTE: only the valid bits and the output word are reset; the datapath registers
   // are qualified by their valid bit, so resetting them would only add muxes.
   always_ff @(posedge clock) begin
      if (clk_en && in_valid) begin
         s1_sign <= fixed_in[FIXED_W-1];
         s1_mag  <= mag;
         s1_pos  <= lead_pos;
         s1_zero <= ~lead_found;
      end
      if (clk_en && s1_valid) begin
         s2_sign <= s1_sign;
         s2_zero <= s1_zero;
         s2_norm <= (FIXED_W-1)'(s1_mag << (FIXED_POS_W'(FIXED_W - 1) - s1_pos));
         s2_exp  <= 9'(FLOAT_BIAS - FRAC_BITS) + 9'(s1_pos);
      end
   end

   always_comb begin
      guard_bit  = s2_norm[7];
      sticky_bit = |s2_norm[6:0];
      lsb_bit    = s2_norm[8];
      round_up   = guard_bit & (sticky_bit | lsb_bit);
      // A carry out of the mantissa leaves it all-zero and bumps the exponent.
      mant_rnd   = {1'b0, s2_norm[30:8]} + (FLOAT_MANT_W+1)'(round_up);
      exp_rnd    = s2_exp + 9'(mant_rnd[FLOAT_MANT_W]);

      packed_word.sign = s2_sign;
      packed_word.exp  = FLOAT_EXP_W'(exp_rnd);
      packed_word.mant = mant_rnd[FLOAT_MANT_W-1:0];
      if (s2_zero) packed_word = '0;
   end

   // Reset wins over clk_en so a stalled pipeline can still be flushed.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         out_valid <= 1'b0;
         float_out <= '0;
      end else if (clk_en) begin
         s1_valid  <= in_valid;
         s2_valid  <= s1_valid;
         out_valid <= s2_valid;
         if (s2_valid) float_out <= packed_word;
      end
   end

endmodule

// File: tb/tb_cordic_fixed_to_float.sv
// Directed and stream checks for cordic_fixed_to_float against hand values and a
// real-arithmetic reference pipeline model.
module tb_cordic_fixed_to_float;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        clk_en;
   logic        in_valid;
   logic [31:0] fixed_in;
   logic        out_valid;
   logic [31:0] float_out;

   int tests_run    = 0;
   int tests_failed = 0;

   // Expected pipeline contents, advanced on every enabled edge.
   logic        mv [3];
   logic [31:0] md [3];

   always #5 clock = ~clock;

   cordic_fixed_to_float #(.FRAC_BITS(31)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .clk_en    (clk_en),
      .in_valid  (in_valid),
      .fixed_in  (fixed_in),
      .out_valid (out_valid),
      .float_out (float_out)
   );

   // Real-valued reference: exact double, then RNE down to single precision.
   function automatic logic [31:0] ref_float(input logic [31:0] x);
      real         r;
      logic [63:0] b;
      logic [23:0] m;
      logic        rnd;
      int          ex;
      r = $itor($signed(x)) / 2147483648.0;
      if (r == 0.0) return 32'h0;
      b   = $realtobits(r);
      m   = {1'b0, b[51:29]};
      rnd = b[28] & ((|b[27:0]) | b[29]);
      m   = m + 24'(rnd);
      ex  = int'(b[62:52]) - 1023 + 127 + int'(m[23]);
      return {b[63], 8'(ex), m[22:0]};
   endfunction

   // Apply inputs, take one rising edge, update the model, return at the falling edge.
   task automatic tick(input logic en, input logic v, input logic [31:0] d);
      clk_en   = en;
      in_valid = v;
      fixed_in = d;
      @(posedge clock);
      if (!reset_n) begin
         for (int i = 0; i < 3; i++) mv[i] = 1'b0;
      end else if (en) begin
         mv[2] = mv[1]; md[2] = md[1];
         mv[1] = mv[0]; md[1] = md[0];
         mv[0] = v;     md[0] = ref_float(d);
      end
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick(1'b0, 1'b1, 32'h4000_0000);
      tick(1'b0, 1'b1, 32'h4000_0000);
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_out_valid got %0b want 0", out_valid);
      end
      tests_run++;
      if (float_out !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_float_out got %08h want 00000000", float_out);
      end
      reset_n = 1'b1;
      tick(1'b1, 1'b0, 32'h0);
   endtask

   task automatic test_directed();
      logic [31:0] vin  [7];
      logic [31:0] vexp [7];
      vin[0] = 32'h6EC1_BCCD; vexp[0] = 32'h3F5D_837A;
      vin[1] = 32'h4000_0000; vexp[1] = 32'h3F00_0000;
      vin[2] = 32'h8000_0000; vexp[2] = 32'hBF80_0000;
      vin[3] = 32'h0000_0000; vexp[3] = 32'h0000_0000;
      vin[4] = 32'h7FFF_FFFF; vexp[4] = 32'h3F80_0000;
      vin[5] = 32'h0100_0001; vexp[5] = 32'h3C00_0000;
      vin[6] = 32'h0100_0003; vexp[6] = 32'h3C00_0002;
      for (int k = 0; k < 7; k++) begin
         tick(1'b1, 1'b1, vin[k]);
         tick(1'b1, 1'b0, 32'h0);
         tests_run++;
         if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL directed%0d_early out_valid got %0b want 0", k, out_valid);
         end
         tick(1'b1, 1'b0, 32'h0);
         tests_run++;
         if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL directed%0d_latency out_valid got %0b want 1", k, out_valid);
         end
         tests_run++;
         if (float_out !== vexp[k]) begin
            tests_failed++;
            $display("FAIL directed%0d_value in %08h got %08h want %08h",
                     k, vin[k], float_out, vexp[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      for (int k = 0; k < 80; k++) begin
         d = $urandom;
         if (k % 7 == 3) d = d >> (k % 29);
         tick(1'b1, 1'($urandom_range(0, 1)), d);
         tests_run++;
         if (out_valid !== mv[2]) begin
            tests_failed++;
            $display("FAIL stream%0d_valid got %0b want %0b", k, out_valid, mv[2]);
         end
         if (mv[2]) begin
            tests_run++;
            if (float_out !== md[2]) begin
               tests_failed++;
               $display("FAIL stream%0d_value got %08h want %08h", k, float_out, md[2]);
            end
         end
      end
   endtask

   task automatic test_stall();
      for (int k = 0; k < 4; k++) tick(1'b1, 1'b1, 32'h1234_5678 + 32'(k) * 32'h0101_0101);
      for (int k = 0; k < 5; k++) begin
         tick(1'b0, 1'b1, $urandom);
         tests_run++;
         if (out_valid !== mv[2]) begin
            tests_failed++;
            $display("FAIL stall%0d_valid got %0b want %0b", k, out_valid, mv[2]);
         end
         tests_run++;
         if (float_out !== md[2]) begin
            tests_failed++;
            $display("FAIL stall%0d_value got %08h want %08h", k, float_out, md[2]);
         end
      end
      for (int k = 0; k < 6; k++) begin
         tick(1'b1, k < 3, 32'hF00D_0000 - 32'(k) * 32'h0031_0001);
         tests_run++;
         if (out_valid !== mv[2]) begin
            tests_failed++;
            $display("FAIL resume%0d_valid got %0b want %0b", k, out_valid, mv[2]);
         end
         if (mv[2]) begin
            tests_run++;
            if (float_out !== md[2]) begin
               tests_failed++;
               $display("FAIL resume%0d_value got %08h want %08h", k, float_out, md[2]);
            end
         end
      end
   endtask

   task automatic test_reset_in_flight();
      tick(1'b1, 1'b1, 32'h6EC1_BCCD);
      tick(1'b1, 1'b1, 32'h8000_0000);
      tick(1'b1, 1'b1, 32'h7FFF_FFFF);
      reset_n = 1'b0;
      tick(1'b0, 1'b0, 32'h0);
      reset_n = 1'b1;
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_out_valid got %0b want 0", out_valid);
      end
      tests_run++;
      if (float_out !== 32'h0) begin
         tests_failed++;
         $display("FAIL flush_float_out got %08h want 00000000", float_out);
      end
      for (int k = 0; k < 5; k++) begin
         tick(1'b1, 1'b0, 32'h0);
         tests_run++;
         if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_stale%0d out_valid got %0b want 0", k, out_valid);
         end
      end
      tick(1'b1, 1'b1, 32'h4000_0000);
      tick(1'b1, 1'b0, 32'h0);
      tick(1'b1, 1'b0, 32'h0);
      tests_run++;
      if (out_valid !== 1'b1 || float_out !== 32'h3F00_0000) begin
         tests_failed++;
         $display("FAIL after_flush got valid %0b data %08h want valid 1 data 3f000000",
                  out_valid, float_out);
      end
   endtask

   initial begin
      reset_n  = 1'b0;
      clk_en   = 1'b0;
      in_valid = 1'b0;
      fixed_in = 32'h0;
      for (int i = 0; i < 3; i++) begin
         mv[i] = 1'b0;
         md[i] = 32'h0;
      end
      @(negedge clock);
      test_reset();
      test_directed();
      test_back_to_back();
      test_stall();
      test_reset_in_flight();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
